// File: rtl/winograd_tile_builder.sv
// winograd_tile_builder: turns a raster pixel stream into overlapping stride-2 4x4 tiles for F(2x2,3x3).
module winograd_tile_builder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pixel_in,
  input  logic                     pixel_valid,
  output logic [0:3][0:3][31:0]    data_out,
  output logic                     next,
  output logic                     tile_last,
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);
  if (IMG_W % 2 != 0 || IMG_W < 4 || IMG_H % 2 != 0 || IMG_H < 4) begin : g_bad_params
    $fatal(1, "winograd_tile_builder: IMG_W and IMG_H must be even and >= 4");
  end
  logic [31:0]               buf_q [0:3][0:IMG_W-1];
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [0:3][0:3][31:0]     data_q, data_d, tile;
  logic                      next_q, next_d, end_q, end_d, trig;
  always_comb begin
    trig   = pixel_valid && row_q[0] && row_q >= RW'(3) && col_q[0] && col_q >= CW'(3);
    end_d  = pixel_valid && row_q == R_MAX && col_q == C_MAX;
    next_d = trig;
    col_d  = pixel_valid ? (col_q == C_MAX ? '0 : col_q + 1'b1) : col_q;
    row_d  = (pixel_valid && col_q == C_MAX) ? (row_q == R_MAX ? '0 : row_q + 1'b1) : row_q;
    tile   = '0;
    // row R-3+i lives in buffer (R+1+i) mod 4; the trigger pixel bypasses its own same-cycle write
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        tile[i][j] = (i == 3 && j == 3) ? pixel_in
                   : buf_q[row_q[1:0] + 2'(i + 1)][col_q - CW'(3 - j)];
    data_d = trig ? tile : data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      data_q <= '0;
      next_q <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      data_q <= data_d;
      next_q <= next_d;
      end_q  <= end_d;
    end
  end
  always_ff @(posedge clk) begin
    if (pixel_valid) buf_q[row_q[1:0]][col_q] <= pixel_in;
  end
  assign data_out   = data_q;
  assign next       = next_q;
  assign tile_last  = end_q;
  assign frame_done = end_q;
endmodule

// File: tb/tb_winograd_tile_builder.sv
// tb_winograd_tile_builder: directed ramp images checked against hand-derived tile contents.
module tb_winograd_tile_builder;
  typedef logic [0:3][0:3][31:0] tile_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [31:0] pixel_in = '0;
  tile_t       data_out, prev_tile;
  logic        next, tile_last, frame_done;
  logic [31:0] acc;
  logic        acc_v = 1'b0;
  logic        prev_next = 1'b0;
  tile_t       tq[$];
  logic [31:0] aq[$];
  logic [2:0]  fq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          fd_cnt = 0;

  always #5 clk = ~clk;

  winograd_tile_builder #(.IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .data_out(data_out), .next(next), .tile_last(tile_last), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    acc   <= pixel_in;
    acc_v <= pixel_valid;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (next) begin
        tq.push_back(data_out);
        aq.push_back(acc);
        fq.push_back({acc_v, tile_last, frame_done});
        check("next_gap", 32'(prev_next), 0);
      end else begin
        check("hold", 32'(data_out == prev_tile), 1);
      end
      check("last_wo_next", 32'(tile_last & ~next), 0);
      if (frame_done) fd_cnt++;
    end
    prev_tile <= data_out;
    prev_next <= next;
  end

  task automatic send(input logic [31:0] p, input logic v);
    @(posedge clk);
    #1;
    pixel_in    = p;
    pixel_valid = v;
  endtask

  task automatic image(input int base, input bit gap);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        send(32'(base + r * 8 + c), 1'b1);
        if (gap) send('0, 1'b0);
      end
  endtask

  task automatic flush();
    repeat (3) send('0, 1'b0);
  endtask

  task automatic clear();
    tq.delete();
    aq.delete();
    fq.delete();
    fd_cnt = 0;
  endtask

  task automatic verify(input string nm, input int n_img, input int b0, input int b1);
    check({nm, "_count"}, 32'(tq.size()), 32'(9 * n_img));
    check({nm, "_frames"}, 32'(fd_cnt), 32'(n_img));
    for (int k = 0; k < tq.size(); k++) begin
      int base, t, rr, cc;
      base = (k < 9) ? b0 : b1;
      t  = k % 9;
      rr = 3 + 2 * (t / 3);
      cc = 3 + 2 * (t % 3);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          check($sformatf("%s_t%0d_d%0d%0d", nm, k, i, j), tq[k][i][j],
                32'(base + (rr - 3 + i) * 8 + cc - 3 + j));
      check($sformatf("%s_t%0d_trig", nm, k), aq[k], 32'(base + rr * 8 + cc));
      check($sformatf("%s_t%0d_trig_v", nm, k), 32'(fq[k][2]), 1);
      check($sformatf("%s_t%0d_last", nm, k), 32'(fq[k][1]), 32'(t == 8));
      check($sformatf("%s_t%0d_done", nm, k), 32'(fq[k][0]), 32'(t == 8));
    end
    clear();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(data_out == '0), 1);
    check("rst_next", 32'(next), 0);
    check("rst_last", 32'(tile_last), 0);
    check("rst_done", 32'(frame_done), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    image(0, 1'b0);
    flush();
    check("ramp_t3_d00", tq.size() > 3 ? tq[3][0][0] : 32'hffff_ffff, 16);
    check("ramp_t3_d33", tq.size() > 3 ? tq[3][3][3] : 32'hffff_ffff, 43);
    verify("ramp", 1, 0, 0);
    image(0, 1'b1);
    flush();
    verify("gap", 1, 0, 0);
    image(0, 1'b0);
    image(100, 1'b0);
    flush();
    check("b2b_t9_d00", tq.size() > 9 ? tq[9][0][0] : 32'hffff_ffff, 100);
    check("b2b_t9_d33", tq.size() > 9 ? tq[9][3][3] : 32'hffff_ffff, 127);
    verify("b2b", 2, 0, 100);
    for (int p = 0; p <= 40; p++) send(32'(p), 1'b1);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    pixel_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_tiles", 32'(tq.size()), 3);
    check("inrst_data", 32'(data_out == '0), 1);
    check("inrst_next", 32'(next), 0);
    clear();
    @(posedge clk);
    #1 reset = 1'b1;
    image(0, 1'b0);
    flush();
    verify("rst", 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/winograd_tile_builder.md
Name: winograd_tile_builder

Overview:
- Upstream feeder for processing_element.
- Converts a raster-order stream of 32-bit pixels, one per cycle when valid, into overlapping 4x4 input tiles with stride 2, as required by the F(2x2,3x3) Winograd datapath.
- Each assembled tile is presented on data_out together with a single-cycle next pulse. This pulse drives the processing element's data_in/next directly.
- Pixel words are opaque 32-bit values (fp32 in practice); the block does no arithmetic on them.

Parameters:
- IMG_W, 8, image width in pixels; must be even, >= 4.
- IMG_H, 8, image height in pixels; must be even, >= 4.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pixel_in  input  32  pixel word, raster order (row-major, column 0 first).
- pixel_valid  input  1  pixel_in is consumed on this cycle.
- data_out  output  32 x [0:3][0:3]  tile; data_out[i][j] = pixel(row R-3+i, col C-3+j).
- next  output  1  one-cycle pulse; data_out holds a new tile.
- tile_last  output  1  asserted with next for the final tile of an image.
- frame_done  output  1  one-cycle pulse after the last pixel of an image is accepted.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - col/row counters = 0; data_out all 0; next, tile_last, frame_done = 0.
  - Line-buffer contents are don't-care after reset.
- Storage:
  - 4 row buffers of IMG_W x 32 bits, indexed by row mod 4.
  - An accepted pixel at (row, col) is written to buffer[row mod 4][col].
- Counters:
  - col advances 0..IMG_W-1 on each valid; at IMG_W-1 it wraps to 0 and row increments.
  - row wraps from IMG_H-1 to 0, which starts a new image with no idle cycle required.
  - With pixel_valid=0 nothing changes; gaps of any length are legal.
- Tile trigger: an accepted pixel at (R, C) with R >= 3, R odd, C >= 3, C odd.
- On the cycle after the trigger:
  - next=1; data_out is loaded with rows R-3..R and cols C-3..C.
  - The triggering pixel itself comes from the pixel_in bypass, not the buffer, because its write lands in the same cycle.
  - Row mapping: tile row i reads buffer[(R-3+i) mod 4].
- data_out holds its value until the next tile is loaded. next is never high for two consecutive cycles, because triggers are at least 2 accepted pixels apart.
- Latency: 1 cycle from the trigger pixel to next.
- Tile count per image: ((IMG_W-2)/2) x ((IMG_H-2)/2); tiles emitted row-major.
- tile_last = next AND (R = IMG_H-1) AND (C = IMG_W-1).
- frame_done: pulses 1 cycle after pixel (IMG_H-1, IMG_W-1) is accepted, i.e. coincident with the last tile's next.
- No backpressure: the downstream processing element is fully pipelined and accepts a tile every cycle.
- Back-to-back images:
  - First tile of image k+1 fires at its pixel (3,3).
  - Rows 0..2 of image k+1 overwrite buffers 0..2 before any read needs them.
  - Stale image-k data is never used.
- Reset mid-image: counters return to 0; the next accepted pixel is treated as (0,0); no partial tile or next is produced for the aborted image.
- Parameter legality (IMG_W/IMG_H even, >= 4) is checked at elaboration with a fatal error.

Test Plan:
- Ramp, IMG_W=IMG_H=8, pixel_in = r*8+c, pixel_valid held high (pixels 0..63):
  - First next occurs 1 cycle after pixel 27 (r3,c3): data_out[0][0]=0, data_out[0][3]=3, data_out[3][0]=24, data_out[3][3]=27.
  - Second next after pixel 29: data_out[0][0]=2, data_out[3][3]=29.
- Same ramp, full image:
  - Exactly 9 next pulses.
  - 4th tile (after pixel 43): data_out[0][0]=16, data_out[3][3]=43.
  - Last tile after pixel 63: data_out[0][0]=36, data_out[3][3]=63, tile_last=1 and frame_done=1 in the same cycle.
- Ramp with pixel_valid toggling 1,0,1,0:
  - Identical tile contents and tile order to the first scenario.
  - Each next still occurs 1 cycle after its trigger pixel.
  - data_out is stable between pulses.
- Two images back-to-back, second image = 100 + r*8+c:
  - The 10th next has data_out[0][0]=100, data_out[3][3]=127.
  - No next fires between pixel 63 of image 1 and pixel 27 of image 2.
- Reset asserted after pixel 40, then ramp restarted from 0:
  - data_out = 0 and next = 0 during reset.
  - After release, first next follows restarted pixel 27, with data_out[3][3]=27 and data_out[0][0]=0.
